// File: rtl/wave_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : wave_i2s_tx
//  Purpose  : Accepts unsigned mono samples over valid/ready and serialises
//             them as a left-justified I2S-style stream (bit clock, word
//             select, serial data). Each sample is sent on both channels of
//             a stereo frame after offset-binary to two's-complement
//             conversion. A starved frame repeats the last sample and
//             raises a one-cycle underrun pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module wave_i2s_tx #(
    parameter int WAVE_DEPTH = 8,
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WAVE_DEPTH-1:0] i_sample,
    input  logic                  i_sample_valid,
    output logic                  o_sample_ready,
    output logic                  o_bit_clock,
    output logic                  o_word_select,
    output logic                  o_serial_data,
    output logic                  o_underrun
);

    localparam int c_cnt_w = $clog2(2 * FRAME_BITS);
    localparam int c_div_w = $clog2(CLK_DIV);

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(2 * FRAME_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_slot_len = c_cnt_w'(FRAME_BITS);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0]    r_div;
    logic                  r_bclk;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [WAVE_DEPTH-1:0] r_hold;
    logic                  r_full;
    logic                  r_consumed;
    logic [WAVE_DEPTH-1:0] r_last;
    logic                  r_sd;
    logic                  r_ws;
    logic                  r_underrun;

    logic                  w_div_end;
    logic                  w_fall;
    logic                  w_frame_start;
    logic                  w_accept;
    logic [c_cnt_w-1:0]    w_cnt_next;
    logic [c_cnt_w-1:0]    w_slot_bit;
    logic [WAVE_DEPTH-1:0] w_last_next;
    logic                  w_sd_bit;

    assign w_div_end     = (r_div == c_div_last);
    // A falling edge is the divider terminal count while the bit clock is high
    assign w_fall        = w_div_end & r_bclk;
    assign w_frame_start = w_fall & (r_cnt == c_cnt_last);
    assign w_accept      = i_sample_valid & ~r_full;
    assign w_cnt_next    = (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
    assign w_slot_bit    = (w_cnt_next >= c_slot_len) ? (w_cnt_next - c_slot_len) : w_cnt_next;

    // The frame's first bit must already come from the newly loaded sample,
    // so the data mux looks at the next-state value of the last-sample register
    assign w_last_next   = (w_frame_start && r_full)
                         ? {~r_hold[WAVE_DEPTH-1], r_hold[WAVE_DEPTH-2:0]}
                         : r_last;

    // Select MSB-first data bit for the current slot position; pad with zeros
    always_comb begin
        w_sd_bit = 1'b0;
        for (int i = 0; i < WAVE_DEPTH; i++) begin
            if (w_slot_bit == c_cnt_w'(i)) begin
                w_sd_bit = w_last_next[WAVE_DEPTH-1-i];
            end
        end
    end

    // Clock divider producing the bit clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_div_end) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    // Bit counter, word select and serial data advance on each falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= c_cnt_last;
            r_ws  <= 1'b0;
            r_sd  <= 1'b0;
        end else if (w_fall) begin
            r_cnt <= w_cnt_next;
            r_ws  <= (w_cnt_next >= c_slot_len);
            r_sd  <= w_sd_bit;
        end
    end

    // Last-sample register: reloaded only at a frame start with a held sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= '0;
        end else begin
            r_last <= w_last_next;
        end
    end

    // Underrun pulse marks a frame start that found the holding register empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_frame_start & ~r_full;
        end
    end

    // Holding register; it is released one cycle after the frame start that
    // consumed it, so ready reappears the cycle after the frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_full     <= 1'b0;
            r_consumed <= 1'b0;
        end else begin
            r_consumed <= w_frame_start & r_full;
            if (r_consumed) begin
                r_full <= 1'b0;
            end else if (w_accept) begin
                r_full <= 1'b1;
                r_hold <= i_sample;
            end
        end
    end

    assign o_sample_ready = ~r_full;
    assign o_bit_clock    = r_bclk;
    assign o_word_select  = r_ws;
    assign o_serial_data  = r_sd;
    assign o_underrun     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_wave_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wave_i2s_tx
//  Purpose  : Directed self-checking bench for wave_i2s_tx. Expected frame
//             contents are queued as samples are driven and compared as the
//             serial frames complete.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wave_i2s_tx;

    typedef struct packed {
        logic [7:0] d;
        logic       ur;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sample_ready;
    logic       bit_clock;
    logic       word_select;
    logic       serial_data;
    logic       underrun;

    int   checks = 0;
    int   errors = 0;
    int   cyc;
    exp_t sb[$];

    wave_i2s_tx #(
        .WAVE_DEPTH (8),
        .FRAME_BITS (16),
        .CLK_DIV    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sample       (sample),
        .i_sample_valid (sample_valid),
        .o_sample_ready (sample_ready),
        .o_bit_clock    (bit_clock),
        .o_word_select  (word_select),
        .o_serial_data  (serial_data),
        .o_underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic goto(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic logic [7:0] cvt(input logic [7:0] s);
        return {~s[7], s[6:0]};
    endfunction

    // Value presented to rising edge e while valid is held during the ramp test
    function automatic logic [7:0] ramp(input int e);
        logic [10:0] v;
        v = e[10:0];
        return v[7:0] + {1'b0, v[10:8], 4'b0000};
    endfunction

    task automatic push(input logic [7:0] d, input logic ur);
        exp_t e;
        e.d  = d;
        e.ur = ur;
        sb.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bclk"},  bit_clock,    1'b0);
        chk({tag, "_ws"},    word_select,  1'b0);
        chk({tag, "_sd"},    serial_data,  1'b0);
        chk({tag, "_ready"}, sample_ready, 1'b1);
        chk({tag, "_ur"},    underrun,     1'b0);
    endtask

    // Serial monitor: reconstructs frames on bit-clock falls and scores them
    initial begin : monitor
        logic        prev;
        logic        fall;
        int          idx;
        int          urc;
        logic [31:0] cap;
        exp_t        e;
        prev = 1'b0; idx = 0; urc = 0; cap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0; idx = 0; urc = 0; cap = '0;
            end else begin
                fall = prev & ~bit_clock;
                if (fall && idx == 0) urc = int'(underrun);
                else                  urc = urc + int'(underrun);
                if (fall) begin
                    chk("ws_slot", word_select, (idx >= 16));
                    cap = {cap[30:0], serial_data};
                    if (idx == 31) begin
                        chk("sb_nonempty", (sb.size() != 0), 1'b1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            chk("frame_data", cap, {e.d, 8'h00, e.d, 8'h00});
                            chk("frame_underrun", urc, e.ur);
                        end
                    end
                    idx = (idx + 1) % 32;
                end
                prev = bit_clock;
            end
        end
    end

    initial begin : stimulus
        rst_n        = 1'b0;
        sample       = 8'h00;
        sample_valid = 1'b0;

        // Reset values and bit-clock timing; 8'hFF presented before first frame
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n        = 1'b1;
        sample       = 8'hFF;
        sample_valid = 1'b1;
        push(cvt(8'hFF), 1'b0);
        goto(1);
        sample_valid = 1'b0;
        chk("acc_ready_low", sample_ready, 1'b0);
        goto(3);  chk("bclk_c3",  bit_clock, 1'b0);
        goto(4);  chk("bclk_c4",  bit_clock, 1'b1);
        goto(7);  chk("bclk_c7",  bit_clock, 1'b1);
        goto(8);  chk("bclk_c8",  bit_clock, 1'b0);
                  chk("ready_fs", sample_ready, 1'b0);
                  chk("ur_f0",    underrun, 1'b0);
        goto(9);  chk("ready_after_fs", sample_ready, 1'b1);
        goto(12); chk("bclk_c12", bit_clock, 1'b1);

        // Samples 8'h00 then 8'h80 in successive frames
        goto(20);
        sample = 8'h00; sample_valid = 1'b1;
        push(cvt(8'h00), 1'b0);
        goto(21);
        sample_valid = 1'b0;
        chk("ready_held", sample_ready, 1'b0);
        goto(135); chk("ws_c135", word_select, 1'b0);
        goto(136); chk("ws_c136", word_select, 1'b1);
        goto(263); chk("ws_c263", word_select, 1'b1);
        goto(264); chk("ws_c264", word_select, 1'b0);
                   chk("ready_f1_fs", sample_ready, 1'b0);
        goto(265); chk("ready_f1_next", sample_ready, 1'b1);
        goto(280);
        sample = 8'h80; sample_valid = 1'b1;
        push(cvt(8'h80), 1'b0);
        goto(281);
        sample_valid = 1'b0;

        // One more sample, then starvation for two frames
        goto(540);
        sample = 8'h35; sample_valid = 1'b1;
        push(cvt(8'h35), 1'b0);
        goto(541);
        sample_valid = 1'b0;
        push(cvt(8'h35), 1'b1);
        push(cvt(8'h35), 1'b1);
        goto(1031); chk("ur_pre",   underrun, 1'b0);
        goto(1032); chk("ur_pulse", underrun, 1'b1);
                    chk("ready_ur", sample_ready, 1'b1);
        goto(1033); chk("ur_post",  underrun, 1'b0);
        goto(1288); chk("ur_f5",    underrun, 1'b1);

        // Valid held high with a ramp: one accept per frame
        goto(1300);
        push(cvt(ramp(1301)), 1'b0);
        push(cvt(ramp(1546)), 1'b0);
        push(cvt(ramp(1802)), 1'b0);
        sample_valid = 1'b1;
        while (cyc < 1804) begin
            if (cyc == 1400) chk("ramp_ready_1400", sample_ready, 1'b0);
            if (cyc == 1544) chk("ramp_ready_1544", sample_ready, 1'b0);
            if (cyc == 1545) chk("ramp_ready_1545", sample_ready, 1'b1);
            if (cyc == 1546) chk("ramp_ready_1546", sample_ready, 1'b0);
            if (cyc == 1700) chk("ramp_ready_1700", sample_ready, 1'b0);
            if (cyc == 1801) chk("ramp_ready_1801", sample_ready, 1'b1);
            if (cyc == 1802) chk("ramp_ready_1802", sample_ready, 1'b0);
            sample = ramp(cyc + 1);
            @(negedge clk);
        end
        sample_valid = 1'b0;

        // Accept coincident with frame start on an empty holding register
        goto(2311);
        push(cvt(ramp(1802)), 1'b1);
        push(cvt(8'h5A), 1'b0);
        sample = 8'h5A; sample_valid = 1'b1;
        goto(2312);
        sample_valid = 1'b0;
        chk("coinc_ur",    underrun, 1'b1);
        chk("coinc_ready", sample_ready, 1'b0);
        goto(2569); chk("coinc_ready_rel", sample_ready, 1'b1);

        // Pending sample, then asynchronous reset in the right slot
        goto(2900);
        sample = 8'h11; sample_valid = 1'b1;
        goto(2901);
        sample_valid = 1'b0;
        goto(2974);
        chk("pre_rst_ws",    word_select, 1'b1);
        chk("pre_rst_ready", sample_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        chk("sb_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst2");
        rst_n = 1'b1;
        push(8'h00, 1'b1);
        goto(3); chk("r2_bclk_c3", bit_clock, 1'b0);
        goto(4); chk("r2_bclk_c4", bit_clock, 1'b1);
        goto(8); chk("r2_bclk_c8", bit_clock, 1'b0);
                 chk("r2_ur",      underrun,  1'b1);
        goto(264);
        chk("sb_final", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
